imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Parametrised, pipelined immediate generator for the RISC-V datapath: extracts and extends the I, S, B, U and J immediates from a full 32-bit instruction word to XLEN bits. It sits between decode and execute in the pipelined core and replaces the single-cycle extender. Inputs and outputs use valid/ready handshaking with a configurable register depth, a flush and an opaque sideband tag.

## Interface
- XLEN, 32: output width; legal values 32 or 64.
- PIPE_STAGES, 1: register stages between input and output; legal 1..3.
- TAG_W, 5: width of the sideband tag carried alongside each immediate.

- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- flush_i  input  1  synchronous flush; kills all in-flight entries.
- in_valid_i  input  1  instruction word and format are valid.
- in_ready_o  output  1  block accepts the input this cycle.
- instr_i  input  32  full instruction word.
- immsrc_i  input  3  immediate format select.
- tag_i  input  TAG_W  sideband, returned unchanged.
- out_valid_o  output  1  result is valid.
- out_ready_i  input  1  consumer accepts the result.
- imm_ext_o  output  XLEN  extended immediate.
- tag_o  output  TAG_W  tag belonging to imm_ext_o.
- illegal_o  output  1  the result came from an unsupported immsrc value.

## Operation
- Decode is combinational on the input, then enters stage 0. Selection by immsrc_i:
  - 000 I: instr[31:20].
  - 001 S: {instr[31:25], instr[11:7]}.
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - 011 U: {instr[31:12], 12'b0}.
  - 100 J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - 101: Z format when the configuration macro is defined; otherwise illegal.
  - 110, 111: illegal. imm = 0 and illegal_o = 1.
- Formats I, S, B, U and J are sign-extended from instr[31] to XLEN. For XLEN=64, U is also sign-extended above bit 31.
- Each stage holds {valid, imm, tag, illegal}. Stage k is ready when it is empty or stage k+1 is ready. The last stage is ready when it is empty or out_ready_i is high.
- A stage loads when its upstream holds valid data and the stage is ready. The stage clears its valid bit when it hands its entry on and receives nothing in return.
- in_ready_o = ready of stage 0. It is combinational from out_ready_i through the chain; there is no skid buffer.
- Outputs: out_valid_o, imm_ext_o, tag_o and illegal_o are driven directly from the last stage.
- flush_i high: all valid bits clear at the next edge. An input offered in the same cycle as the flush is dropped, even if in_ready_o is high. Data registers are not cleared.
- Reset (rst_ni low, at any time including mid-transfer): all valid bits and all data registers are forced to 0 immediately. After reset, out_valid_o=0, imm_ext_o=0, tag_o=0 and illegal_o=0.

## Timing
- Latency is PIPE_STAGES cycles from an accepted input to out_valid_o, when there is no backpressure.
- Throughput is one result per cycle while out_ready_i stays high.
- Stall: when out_ready_i is low with the output valid, imm_ext_o, tag_o and illegal_o hold stable until the handshake completes.
- Full condition: all stages valid and out_ready_i low. Then in_ready_o = 0.
- Simultaneous consume and accept on a full pipe:
  - If out_ready_i is high, in_ready_o is also high in the same cycle.
  - All stages shift together with no bubble.
- Ordering is strictly FIFO. Tags exit in the order they entered.

## Configuration
- IMM_GEN_ZIMM_EN defined: immsrc 101 selects the CSR zimm format. imm = zero-extended instr[19:15] and illegal_o = 0.
- IMM_GEN_ZIMM_EN undefined: immsrc 101 is illegal. imm = 0 and illegal_o = 1.

## Test plan
- I and J, XLEN=32, PIPE_STAGES=1:
  - instr 0xFFF00093 with immsrc 000 -> imm 0xFFFFFFFF one cycle later.
  - instr 0xFFDFF06F with immsrc 100 -> imm 0xFFFFFFFC.
- S and B:
  - instr 0xFE512E23 with immsrc 001 -> imm 0xFFFFFFFC.
  - instr 0xFE000EE3 with immsrc 010 -> imm 0xFFFFFFFC.
- U sign extension:
  - instr 0x800000B7 with immsrc 011, XLEN=32 -> 0x80000000.
  - Same input, XLEN=64 -> 0xFFFFFFFF80000000.
- Backpressure, PIPE_STAGES=3:
  - Stream tags 0..5 with out_ready_i held low for 4 cycles.
  - Pipe fills with three entries and in_ready_o goes low.
  - After release, tags 0..5 exit in order, one per cycle, with outputs stable throughout the stall.
- Flush and reset:
  - flush_i asserted with three entries in flight -> out_valid_o = 0 on the next cycle and no stale tag ever appears.
  - rst_ni pulsed low mid-stream -> all outputs 0 asynchronously.
- Illegal format and macro:
  - immsrc 111 -> illegal_o = 1 and imm 0.
  - immsrc 101 with instr 0x0001D073:
    - Macro defined -> imm 0x00000003 and illegal_o = 0.
    - Macro undefined -> illegal_o = 1.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with valid/ready handshake, flush and sideband tag.
// Optional macro IMM_GEN_ZIMM_EN enables the CSR zimm format on immsrc 101.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [2:0]       immsrc_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_ext_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o
);

  localparam int LAST = PIPE_STAGES - 1;

  logic [31:0]     dec_imm32;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;
  logic            unused_opcode;

  // The opcode field never contributes to any immediate.
  assign unused_opcode = ^instr_i[6:0];

  always_comb begin
    dec_imm32 = '0;
    dec_ill   = 1'b0;
    case (immsrc_i)
      3'b000: dec_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      3'b001: dec_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      3'b010: dec_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
      3'b011: dec_imm32 = {instr_i[31:12], 12'b0};
      3'b100: dec_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
      3'b101: dec_imm32 = {27'b0, instr_i[19:15]};
`else
      3'b101: dec_ill   = 1'b1;
`endif
      default: dec_ill  = 1'b1;
    endcase
  end

  // Bit 31 of the 32-bit result already carries the right sign (zero for zimm/illegal).
  generate
    if (XLEN > 32) begin : g_wide
      assign dec_imm = {{(XLEN-32){dec_imm32[31]}}, dec_imm32};
    end else begin : g_narrow
      assign dec_imm = dec_imm32[XLEN-1:0];
    end
  endgenerate

  logic [PIPE_STAGES-1:0] st_valid;
  logic [PIPE_STAGES-1:0] st_ill;
  logic [XLEN-1:0]        st_imm [PIPE_STAGES];
  logic [TAG_W-1:0]       st_tag [PIPE_STAGES];

  logic [PIPE_STAGES-1:0] st_ready;
  logic [PIPE_STAGES-1:0] ds_ready;
  logic [PIPE_STAGES-1:0] st_load;
  logic [PIPE_STAGES-1:0] st_take;
  logic [PIPE_STAGES-1:0] up_valid;
  logic [PIPE_STAGES-1:0] up_ill;
  logic [XLEN-1:0]        up_imm [PIPE_STAGES];
  logic [TAG_W-1:0]       up_tag [PIPE_STAGES];

  generate
    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
      // Unrolled ready chain: a stage can accept unless it and everything after it is full and stalled.
      assign st_ready[k] = out_ready_i | ~(&st_valid[LAST:k]);

      if (k == LAST) begin : g_last
        assign ds_ready[k] = out_ready_i;
      end else begin : g_mid
        assign ds_ready[k] = st_ready[k+1];
      end

      if (k == 0) begin : g_head
        assign up_valid[k] = in_valid_i & ~flush_i;
        assign up_ill[k]   = dec_ill;
        assign up_imm[k]   = dec_imm;
        assign up_tag[k]   = tag_i;
      end else begin : g_tail
        assign up_valid[k] = st_valid[k-1];
        assign up_ill[k]   = st_ill[k-1];
        assign up_imm[k]   = st_imm[k-1];
        assign up_tag[k]   = st_tag[k-1];
      end

      assign st_load[k] = up_valid[k] & st_ready[k];
      assign st_take[k] = st_valid[k] & ds_ready[k];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_valid <= '0;
      st_ill   <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        st_imm[k] <= '0;
        st_tag[k] <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (flush_i)
          st_valid[k] <= 1'b0;
        else if (st_load[k])
          st_valid[k] <= 1'b1;
        else if (st_take[k])
          st_valid[k] <= 1'b0;

        if (st_load[k]) begin
          st_imm[k] <= up_imm[k];
          st_tag[k] <= up_tag[k];
          st_ill[k] <= up_ill[k];
        end
      end
    end
  end

  assign in_ready_o  = st_ready[0];
  assign out_valid_o = st_valid[LAST];
  assign imm_ext_o   = st_imm[LAST];
  assign tag_o       = st_tag[LAST];
  assign illegal_o   = st_ill[LAST];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: dut_a is XLEN=32/1 stage, dut_b is XLEN=64/3 stages.
module tb_imm_gen_pipe;

  logic clk;
  logic rst_n;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ill;
  logic [31:0] a_instr, a_imm;
  logic [2:0]  a_src;
  logic [4:0]  a_tag_in, a_tag_out;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ill;
  logic [31:0] b_instr;
  logic [63:0] b_imm;
  logic [2:0]  b_src;
  logic [4:0]  b_tag_in, b_tag_out;

  int passCount = 0;
  int checkCount = 0;
  int failCount = 0;
  int sent;
  int rcvd;

  imm_gen_pipe #(.XLEN(32), .PIPE_STAGES(1), .TAG_W(5)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .instr_i(a_instr), .immsrc_i(a_src), .tag_i(a_tag_in),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .imm_ext_o(a_imm), .tag_o(a_tag_out), .illegal_o(a_ill)
  );

  imm_gen_pipe #(.XLEN(64), .PIPE_STAGES(3), .TAG_W(5)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .instr_i(b_instr), .immsrc_i(b_src), .tag_i(b_tag_in),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .imm_ext_o(b_imm), .tag_o(b_tag_out), .illegal_o(b_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  // Offer one word to dut_a, then leave the bench one edge later at posedge+1.
  task automatic applyStimulus(input logic [31:0] instr, input logic [2:0] src,
                               input logic [4:0] tag);
    @(posedge clk); #1;
    a_in_valid = 1'b1;
    a_instr    = instr;
    a_src      = src;
    a_tag_in   = tag;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    a_instr = '0; a_src = '0; a_tag_in = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    b_instr = '0; b_src = '0; b_tag_in = '0;

    #2;
    checkOutput("rst_a_valid", a_out_valid, 0);
    checkOutput("rst_a_imm", a_imm, 0);
    checkOutput("rst_a_tag", a_tag_out, 0);
    checkOutput("rst_a_ill", a_ill, 0);
    checkOutput("rst_b_valid", b_out_valid, 0);
    checkOutput("rst_b_imm", b_imm, 0);
    #10 rst_n = 1'b1;

    applyStimulus(32'hFFF0_0093, 3'b000, 5'd1);
    checkOutput("i_valid", a_out_valid, 1);
    checkOutput("i_imm", a_imm, 64'hFFFF_FFFF);
    checkOutput("i_tag", a_tag_out, 1);
    checkOutput("i_ill", a_ill, 0);

    applyStimulus(32'hFFDF_F06F, 3'b100, 5'd2);
    checkOutput("j_imm", a_imm, 64'hFFFF_FFFC);
    checkOutput("j_tag", a_tag_out, 2);

    applyStimulus(32'hFE51_2E23, 3'b001, 5'd3);
    checkOutput("s_imm", a_imm, 64'hFFFF_FFFC);

    applyStimulus(32'hFE00_0EE3, 3'b010, 5'd4);
    checkOutput("b_imm", a_imm, 64'hFFFF_FFFC);

    applyStimulus(32'h8000_00B7, 3'b011, 5'd5);
    checkOutput("u32_imm", a_imm, 64'h8000_0000);

    applyStimulus(32'hFFFF_FFFF, 3'b111, 5'd6);
    checkOutput("ill7_imm", a_imm, 0);
    checkOutput("ill7_flag", a_ill, 1);

    applyStimulus(32'h0001_D073, 3'b101, 5'd9);
`ifdef IMM_GEN_ZIMM_EN
    checkOutput("zimm_imm", a_imm, 64'h3);
    checkOutput("zimm_ill", a_ill, 0);
`else
    checkOutput("zimm_imm", a_imm, 0);
    checkOutput("zimm_ill", a_ill, 1);
`endif

    // U format through the three-stage 64-bit instance, checking latency
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_instr = 32'h8000_00B7; b_src = 3'b011; b_tag_in = 5'd3;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    checkOutput("u64_lat1", b_out_valid, 0);
    @(posedge clk); #1;
    checkOutput("u64_lat2", b_out_valid, 0);
    @(posedge clk); #1;
    checkOutput("u64_valid", b_out_valid, 1);
    checkOutput("u64_imm", b_imm, 64'hFFFF_FFFF_8000_0000);
    checkOutput("u64_tag", b_tag_out, 3);

    // Backpressure: tags 0..5 with out_ready low for the first four cycles
    sent = 0;
    rcvd = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      b_out_ready = (c >= 4);
      b_in_valid  = (sent < 6);
      b_instr     = (32'(sent) << 20) | 32'h0000_0013;
      b_src       = 3'b000;
      b_tag_in    = 5'(sent);
      @(negedge clk);
      checkOutput("bp_in_ready", b_in_ready, (c != 3));
      checkOutput("bp_out_valid", b_out_valid, (c >= 3 && c <= 9));
      if (b_out_valid) begin
        checkOutput("bp_tag", b_tag_out, 64'(rcvd));
        checkOutput("bp_imm", b_imm, 64'(rcvd));
        if (b_out_ready) rcvd++;
      end
      if (b_in_valid && b_in_ready) sent++;
    end
    b_in_valid = 1'b0;
    checkOutput("bp_count", 64'(rcvd), 6);

    // Flush with three entries in flight; the input offered alongside is dropped
    for (int f = 0; f < 4; f++) begin
      @(posedge clk); #1;
      b_out_ready = 1'b0;
      b_in_valid  = 1'b1;
      b_tag_in    = 5'(10 + f);
      b_instr     = (32'(10 + f) << 20) | 32'h0000_0013;
      b_flush     = (f == 3);
    end
    @(negedge clk);
    checkOutput("fl_full_valid", b_out_valid, 1);
    checkOutput("fl_full_tag", b_tag_out, 10);
    checkOutput("fl_full_ready", b_in_ready, 0);
    for (int f = 0; f < 4; f++) begin
      @(posedge clk); #1;
      b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
      @(negedge clk);
      checkOutput("fl_empty", b_out_valid, 0);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_instr = 32'hFFF0_0093; b_src = 3'b000; b_tag_in = 5'd20;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    checkOutput("fl_after_valid", b_out_valid, 1);
    checkOutput("fl_after_tag", b_tag_out, 20);
    checkOutput("fl_after_imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);

    // Asynchronous reset while dut_a holds a stalled result
    a_out_ready = 1'b0;
    applyStimulus(32'hFFF0_0093, 3'b000, 5'd7);
    checkOutput("ar_pre_valid", a_out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_a_valid", a_out_valid, 0);
    checkOutput("ar_a_imm", a_imm, 0);
    checkOutput("ar_a_tag", a_tag_out, 0);
    checkOutput("ar_a_ill", a_ill, 0);
    checkOutput("ar_b_valid", b_out_valid, 0);
    checkOutput("ar_b_imm", b_imm, 0);
    #3 rst_n = 1'b1;

    if (failCount != 0) $display("[TB] %0d checks did not match", failCount);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
